issue_bypass_stage: RTL and testbench

Parametrised successor to the combinational decode/forward logic. It sits between decode and execute and owns operand bypassing from NUM_FWD producer stages. It also detects load-use and long-latency (mul/div) hazards through a per-register scoreboard. Results go into a registered ID/EX slot with a valid/ready handshake, so the stage can stall and be back-pressured.

---
 rtl/issue_bypass_stage_pkg.sv | 32 +++
 rtl/issue_bypass_stage_if.sv | 57 +++++
 rtl/issue_bypass_stage_operand_fwd_mux.sv | 34 +++
 rtl/issue_bypass_stage.sv | 148 ++++++++++++++
 tb/tb_issue_bypass_stage.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_bypass_stage_pkg.sv
// Shared types and constants for the issue/bypass stage.
package issue_bypass_stage_pkg;

   localparam int unsigned REG_IDX_W   = 5;
   localparam int unsigned NUM_REGS    = 32;
   localparam int unsigned STALL_CNT_W = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_X0 = 5'd0;

   // Bypass source slots, youngest first (lower index wins).
   localparam int unsigned FWD_IDX_EX  = 0;
   localparam int unsigned FWD_IDX_MEM = 1;
   localparam int unsigned FWD_IDX_WB  = 2;

   // Field layout of the opaque decoded bundle carried to EX.
   localparam int unsigned PL_ALUOP_LSB  = 0;
   localparam int unsigned PL_ALUOP_W    = 5;
   localparam int unsigned PL_FUNCT3_LSB = 5;
   localparam int unsigned PL_FUNCT3_W   = 3;
   localparam int unsigned PL_IMM_LSB    = 8;
   localparam int unsigned PL_IMM_W      = 32;
   localparam int unsigned PL_PC_LSB     = 40;
   localparam int unsigned PL_PC_W       = 64;

   // One-hot register mask, used for scoreboard set/clear.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
      reg_onehot = NUM_REGS'(1) << idx;
   endfunction

endpackage

// File: rtl/issue_bypass_stage_if.sv
// Decode -> issue -> EX bus, with bypass and long-op completion inputs.
interface issue_bypass_stage_if
   import issue_bypass_stage_pkg::*;
#(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned NUM_FWD   = 3,
   parameter int unsigned PAYLOAD_W = 128
);
   logic                         id_valid_i;
   logic                         id_ready_o;
   reg_idx_t                     rs1_i;
   reg_idx_t                     rs2_i;
   logic                         use_rs1_i;
   logic                         use_rs2_i;
   reg_idx_t                     rd_i;
   logic                         rf_wen_i;
   logic                         is_long_i;
   logic [PAYLOAD_W-1:0]         payload_i;
   logic [XLEN-1:0]              rs1val_i;
   logic [XLEN-1:0]              rs2val_i;
   logic [NUM_FWD-1:0]           fwd_wen_i;
   logic [NUM_FWD-1:0]           fwd_rdy_i;
   logic [REG_IDX_W*NUM_FWD-1:0] fwd_rd_i;
   logic [XLEN*NUM_FWD-1:0]      fwd_data_i;
   logic                         long_done_i;
   reg_idx_t                     long_done_rd_i;
   logic                         flush_i;
   logic                         ex_valid_o;
   logic                         ex_ready_i;
   logic [XLEN-1:0]              ex_src1_o;
   logic [XLEN-1:0]              ex_src2_o;
   reg_idx_t                     ex_rd_o;
   logic                         ex_rf_wen_o;
   logic [PAYLOAD_W-1:0]         ex_payload_o;
   logic [STALL_CNT_W-1:0]       stall_cycles_o;

   // Stage view.
   modport slave (
      input  id_valid_i, rs1_i, rs2_i, use_rs1_i, use_rs2_i, rd_i, rf_wen_i,
             is_long_i, payload_i, rs1val_i, rs2val_i, fwd_wen_i, fwd_rdy_i,
             fwd_rd_i, fwd_data_i, long_done_i, long_done_rd_i, flush_i,
             ex_ready_i,
      output id_ready_o, ex_valid_o, ex_src1_o, ex_src2_o, ex_rd_o,
             ex_rf_wen_o, ex_payload_o, stall_cycles_o
   );

   // Decode/pipeline view driving the stage.
   modport master (
      output id_valid_i, rs1_i, rs2_i, use_rs1_i, use_rs2_i, rd_i, rf_wen_i,
             is_long_i, payload_i, rs1val_i, rs2val_i, fwd_wen_i, fwd_rdy_i,
             fwd_rd_i, fwd_data_i, long_done_i, long_done_rd_i, flush_i,
             ex_ready_i,
      input  id_ready_o, ex_valid_o, ex_src1_o, ex_src2_o, ex_rd_o,
             ex_rf_wen_o, ex_payload_o, stall_cycles_o
   );

endinterface

// File: rtl/issue_bypass_stage_operand_fwd_mux.sv
// Resolves one source operand: x0, youngest matching bypass source, else regfile.
module operand_fwd_mux
   import issue_bypass_stage_pkg::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned NUM_FWD = 3
) (
   input  reg_idx_t                     idx,
   input  logic [XLEN-1:0]              rf_val,
   input  logic [NUM_FWD-1:0]           fwd_wen,
   input  logic [NUM_FWD-1:0]           fwd_rdy,
   input  logic [REG_IDX_W*NUM_FWD-1:0] fwd_rd,
   input  logic [XLEN*NUM_FWD-1:0]      fwd_data,
   output logic [XLEN-1:0]              val_c,
   output logic                         not_ready_c
);

   // Scan oldest to youngest so the lowest matching index ends up selected.
   always_comb begin
      val_c       = rf_val;
      not_ready_c = 1'b0;
      for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
         if (fwd_wen[k] && (fwd_rd[k*REG_IDX_W +: REG_IDX_W] == idx)) begin
            val_c       = fwd_data[k*XLEN +: XLEN];
            not_ready_c = ~fwd_rdy[k];
         end
      end
      if (idx == REG_X0) begin
         val_c       = '0;
         not_ready_c = 1'b0;
      end
   end

endmodule

// File: rtl/issue_bypass_stage.sv
// Issue stage: operand bypass, load-use/long-op hazard scoreboard, registered
// ID/EX slot with valid/ready. Optional stall counter under ISSUE_PERF_EN.
module issue_bypass_stage
   import issue_bypass_stage_pkg::*;
#(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned NUM_FWD   = 3,
   parameter int unsigned PAYLOAD_W = 128,
   parameter int unsigned LONG_MAX  = 2
) (
   input logic                  clock,
   input logic                  reset,
   issue_bypass_stage_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(LONG_MAX + 1);

   logic [XLEN-1:0]      src1_c;
   logic [XLEN-1:0]      src2_c;
   logic                 nr1_c;
   logic                 nr2_c;
   logic                 hazard;
   logic                 id_ready;
   logic                 issue;
   logic                 long_issue;
   logic                 done_eff;
   logic                 sb_set;
   logic [NUM_REGS-1:0]  sb_q;
   logic [NUM_REGS-1:0]  sb_d;
   logic [CNT_W-1:0]     cnt_q;

   logic                 ex_valid_q;
   logic [XLEN-1:0]      ex_src1_q;
   logic [XLEN-1:0]      ex_src2_q;
   reg_idx_t             ex_rd_q;
   logic                 ex_rf_wen_q;
   logic [PAYLOAD_W-1:0] ex_payload_q;

   operand_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
      .idx         (bus.rs1_i),
      .rf_val      (bus.rs1val_i),
      .fwd_wen     (bus.fwd_wen_i),
      .fwd_rdy     (bus.fwd_rdy_i),
      .fwd_rd      (bus.fwd_rd_i),
      .fwd_data    (bus.fwd_data_i),
      .val_c       (src1_c),
      .not_ready_c (nr1_c)
   );

   operand_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
      .idx         (bus.rs2_i),
      .rf_val      (bus.rs2val_i),
      .fwd_wen     (bus.fwd_wen_i),
      .fwd_rdy     (bus.fwd_rdy_i),
      .fwd_rd      (bus.fwd_rd_i),
      .fwd_data    (bus.fwd_data_i),
      .val_c       (src2_c),
      .not_ready_c (nr2_c)
   );

   // Hazard detection and issue handshake.
   always_comb begin
      hazard = 1'b0;
      if (bus.use_rs1_i && (nr1_c || sb_q[bus.rs1_i]))
         hazard = 1'b1;
      if (bus.use_rs2_i && (nr2_c || sb_q[bus.rs2_i]))
         hazard = 1'b1;
      if (bus.rf_wen_i && (bus.rd_i != REG_X0) && sb_q[bus.rd_i])
         hazard = 1'b1;
      if (bus.is_long_i && (cnt_q == CNT_W'(LONG_MAX)))
         hazard = 1'b1;
      id_ready   = (~ex_valid_q | bus.ex_ready_i) & ~hazard & ~bus.flush_i;
      issue      = bus.id_valid_i & id_ready;
      long_issue = issue & bus.is_long_i;
      sb_set     = long_issue & bus.rf_wen_i & (bus.rd_i != REG_X0);
      done_eff   = bus.long_done_i & (cnt_q != '0);
   end

   // Scoreboard next state: completion clears, a same-cycle issue set wins.
   always_comb begin
      sb_d = sb_q;
      if (bus.long_done_i)
         sb_d = sb_d & ~reg_onehot(bus.long_done_rd_i);
      if (sb_set)
         sb_d = sb_d | reg_onehot(bus.rd_i);
      sb_d[0] = 1'b0;
   end

   // ID/EX slot: load on issue, drop valid on consume or flush, data holds.
   always_ff @(posedge clock) begin
      if (reset) begin
         ex_valid_q   <= 1'b0;
         ex_src1_q    <= '0;
         ex_src2_q    <= '0;
         ex_rd_q      <= '0;
         ex_rf_wen_q  <= 1'b0;
         ex_payload_q <= '0;
      end else if (issue) begin
         ex_valid_q   <= 1'b1;
         ex_src1_q    <= src1_c;
         ex_src2_q    <= src2_c;
         ex_rd_q      <= bus.rd_i;
         ex_rf_wen_q  <= bus.rf_wen_i;
         ex_payload_q <= bus.payload_i;
      end else if (bus.ex_ready_i || bus.flush_i) begin
         ex_valid_q   <= 1'b0;
      end
   end

   // Scoreboard and outstanding long-op count; flush leaves both alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         sb_q  <= '0;
         cnt_q <= '0;
      end else begin
         sb_q <= sb_d;
         if (long_issue && !done_eff)
            cnt_q <= cnt_q + CNT_W'(1);
         else if (!long_issue && done_eff)
            cnt_q <= cnt_q - CNT_W'(1);
      end
   end

`ifdef ISSUE_PERF_EN
   logic [STALL_CNT_W-1:0] stall_q;

   // Saturating count of cycles a valid instruction is held by a hazard.
   always_ff @(posedge clock) begin
      if (reset)
         stall_q <= '0;
      else if (bus.id_valid_i && hazard && !bus.flush_i && (stall_q != '1))
         stall_q <= stall_q + STALL_CNT_W'(1);
   end

   assign bus.stall_cycles_o = stall_q;
`else
   assign bus.stall_cycles_o = '0;
`endif

   assign bus.id_ready_o   = id_ready;
   assign bus.ex_valid_o   = ex_valid_q;
   assign bus.ex_src1_o    = ex_src1_q;
   assign bus.ex_src2_o    = ex_src2_q;
   assign bus.ex_rd_o      = ex_rd_q;
   assign bus.ex_rf_wen_o  = ex_rf_wen_q;
   assign bus.ex_payload_o = ex_payload_q;

endmodule

// File: tb/tb_issue_bypass_stage.sv
// Directed bench for issue_bypass_stage (NUM_FWD=3, LONG_MAX=2).
module tb_issue_bypass_stage;

   localparam int unsigned XLEN      = 64;
   localparam int unsigned NUM_FWD   = 3;
   localparam int unsigned PAYLOAD_W = 128;
   localparam int unsigned LONG_MAX  = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   issue_bypass_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .PAYLOAD_W(PAYLOAD_W)) bus ();

   issue_bypass_stage #(
      .XLEN(XLEN), .NUM_FWD(NUM_FWD), .PAYLOAD_W(PAYLOAD_W), .LONG_MAX(LONG_MAX)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic idle;
      bus.id_valid_i     = 1'b0;
      bus.rs1_i          = '0;
      bus.rs2_i          = '0;
      bus.use_rs1_i      = 1'b0;
      bus.use_rs2_i      = 1'b0;
      bus.rd_i           = '0;
      bus.rf_wen_i       = 1'b0;
      bus.is_long_i      = 1'b0;
      bus.payload_i      = '0;
      bus.rs1val_i       = '0;
      bus.rs2val_i       = '0;
      bus.fwd_wen_i      = '0;
      bus.fwd_rdy_i      = '0;
      bus.fwd_rd_i       = '0;
      bus.fwd_data_i     = '0;
      bus.long_done_i    = 1'b0;
      bus.long_done_rd_i = '0;
      bus.flush_i        = 1'b0;
      bus.ex_ready_i     = 1'b1;
   endtask

   task automatic test_reset;
      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      settle();
      n_vec++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.ex_valid_o); end
      n_vec++; if (bus.ex_src1_o !== 64'h0) begin n_err++; $display("FAIL reset_src1: got %h want 0", bus.ex_src1_o); end
      n_vec++; if (bus.ex_src2_o !== 64'h0) begin n_err++; $display("FAIL reset_src2: got %h want 0", bus.ex_src2_o); end
      n_vec++; if (bus.ex_rd_o !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", bus.ex_rd_o); end
      n_vec++; if (bus.ex_rf_wen_o !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %b want 0", bus.ex_rf_wen_o); end
      n_vec++; if (bus.ex_payload_o !== 128'h0) begin n_err++; $display("FAIL reset_payload: got %h want 0", bus.ex_payload_o); end
      n_vec++; if (bus.stall_cycles_o !== 32'h0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles_o); end
      n_vec++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.id_ready_o); end
   endtask

   task automatic test_bypass_priority;
      idle();
      bus.id_valid_i = 1'b1;
      bus.rs1_i      = 5'd5;  bus.use_rs1_i = 1'b1; bus.rs1val_i = 64'hBAD;
      bus.rs2_i      = 5'd6;  bus.use_rs2_i = 1'b1; bus.rs2val_i = 64'h600D;
      bus.rd_i       = 5'd3;  bus.rf_wen_i  = 1'b1;
      bus.payload_i  = 128'hCAFE_0001;
      bus.fwd_wen_i  = 3'b111;
      bus.fwd_rdy_i  = 3'b111;
      bus.fwd_rd_i   = {5'd5, 5'd5, 5'd5};
      bus.fwd_data_i = {64'h33, 64'h22, 64'h11};
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL byp_ready: got %b want 1", bus.id_ready_o); end
      step();
      n_vec++; if (bus.ex_valid_o !== 1'b1) begin n_err++; $display("FAIL byp_valid: got %b want 1", bus.ex_valid_o); end
      n_vec++; if (bus.ex_src1_o !== 64'h11) begin n_err++; $display("FAIL byp_ex: got %h want 11", bus.ex_src1_o); end
      n_vec++; if (bus.ex_src2_o !== 64'h600D) begin n_err++; $display("FAIL byp_rf2: got %h want 600d", bus.ex_src2_o); end
      n_vec++; if (bus.ex_rd_o !== 5'd3) begin n_err++; $display("FAIL byp_rd: got %0d want 3", bus.ex_rd_o); end
      n_vec++; if (bus.ex_payload_o !== 128'hCAFE_0001) begin n_err++; $display("FAIL byp_payload: got %h want cafe0001", bus.ex_payload_o); end
      bus.fwd_wen_i = 3'b110;
      bus.payload_i = 128'hCAFE_0002;
      settle();
      step();
      n_vec++; if (bus.ex_src1_o !== 64'h22) begin n_err++; $display("FAIL byp_mem: got %h want 22", bus.ex_src1_o); end
      bus.fwd_wen_i = 3'b000;
      settle();
      step();
      n_vec++; if (bus.ex_src1_o !== 64'hBAD) begin n_err++; $display("FAIL byp_rf1: got %h want bad", bus.ex_src1_o); end
   endtask

   task automatic test_load_use;
      idle();
      bus.id_valid_i = 1'b1;
      bus.rs1_i      = 5'd1;  bus.use_rs1_i = 1'b0;
      bus.rs2_i      = 5'd7;  bus.use_rs2_i = 1'b1;
      bus.rd_i       = 5'd8;  bus.rf_wen_i  = 1'b1;
      bus.fwd_wen_i  = 3'b001;
      bus.fwd_rdy_i  = 3'b110;
      bus.fwd_rd_i   = {5'd0, 5'd0, 5'd7};
      bus.fwd_data_i = {64'h0, 64'h0, 64'h0};
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL lu_stall: got %b want 0", bus.id_ready_o); end
      step();
      n_vec++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %b want 0", bus.ex_valid_o); end
      bus.fwd_wen_i  = 3'b010;
      bus.fwd_rdy_i  = 3'b010;
      bus.fwd_rd_i   = {5'd0, 5'd7, 5'd0};
      bus.fwd_data_i = {64'h0, 64'hABCD, 64'h0};
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL lu_release: got %b want 1", bus.id_ready_o); end
      step();
      n_vec++; if (bus.ex_src2_o !== 64'hABCD) begin n_err++; $display("FAIL lu_src2: got %h want abcd", bus.ex_src2_o); end
      n_vec++; if (bus.ex_rd_o !== 5'd8) begin n_err++; $display("FAIL lu_rd: got %0d want 8", bus.ex_rd_o); end
   endtask

   task automatic test_x0;
      idle();
      bus.id_valid_i = 1'b1;
      bus.rs1_i      = 5'd0;  bus.use_rs1_i = 1'b1; bus.rs1val_i = 64'h5555;
      bus.rd_i       = 5'd2;  bus.rf_wen_i  = 1'b1;
      bus.fwd_wen_i  = 3'b001;
      bus.fwd_rdy_i  = 3'b000;
      bus.fwd_rd_i   = {5'd0, 5'd0, 5'd0};
      bus.fwd_data_i = {64'h0, 64'h0, 64'hDEAD};
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", bus.id_ready_o); end
      step();
      n_vec++; if (bus.ex_src1_o !== 64'h0) begin n_err++; $display("FAIL x0_src1: got %h want 0", bus.ex_src1_o); end
   endtask

   task automatic test_scoreboard;
      idle();
      bus.id_valid_i = 1'b1;
      bus.is_long_i  = 1'b1; bus.rf_wen_i = 1'b1; bus.rd_i = 5'd9;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL sb_div: got %b want 1", bus.id_ready_o); end
      step();
      bus.rd_i = 5'd10;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL sb_mul: got %b want 1", bus.id_ready_o); end
      step();
      n_vec++; if (bus.ex_rd_o !== 5'd10) begin n_err++; $display("FAIL sb_mul_rd: got %0d want 10", bus.ex_rd_o); end
      bus.rd_i = 5'd11;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL sb_capacity: got %b want 0", bus.id_ready_o); end
      bus.is_long_i = 1'b0; bus.rd_i = 5'd12;
      bus.rs1_i = 5'd9; bus.use_rs1_i = 1'b1;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL sb_raw: got %b want 0", bus.id_ready_o); end
      step();
      n_vec++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL sb_bubble: got %b want 0", bus.ex_valid_o); end
      bus.long_done_i = 1'b1; bus.long_done_rd_i = 5'd9;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL sb_done_cycle: got %b want 0", bus.id_ready_o); end
      step();
      bus.long_done_i = 1'b0;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL sb_cleared: got %b want 1", bus.id_ready_o); end
      step();
      n_vec++; if (bus.ex_rd_o !== 5'd12 || bus.ex_valid_o !== 1'b1) begin n_err++; $display("FAIL sb_add_issue: got rd %0d v %b want rd 12 v 1", bus.ex_rd_o, bus.ex_valid_o); end
      bus.rs1_i = 5'd0; bus.use_rs1_i = 1'b0; bus.rd_i = 5'd10;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL sb_waw: got %b want 0", bus.id_ready_o); end
      bus.long_done_i = 1'b1; bus.long_done_rd_i = 5'd10;
      step();
      bus.long_done_i = 1'b0;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL sb_waw_clear: got %b want 1", bus.id_ready_o); end
      step();
   endtask

   task automatic test_backpressure_flush;
      idle();
      bus.id_valid_i = 1'b1;
      bus.is_long_i  = 1'b1; bus.rf_wen_i = 1'b1; bus.rd_i = 5'd14;
      bus.payload_i  = 128'h14;
      settle();
      step();
      bus.ex_ready_i = 1'b0;
      bus.is_long_i  = 1'b0; bus.rd_i = 5'd5; bus.payload_i = 128'h05;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", bus.id_ready_o); end
      step();
      step();
      n_vec++; if (bus.ex_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", bus.ex_valid_o); end
      n_vec++; if (bus.ex_rd_o !== 5'd14) begin n_err++; $display("FAIL bp_rd_hold: got %0d want 14", bus.ex_rd_o); end
      n_vec++; if (bus.ex_payload_o !== 128'h14) begin n_err++; $display("FAIL bp_payload_hold: got %h want 14", bus.ex_payload_o); end
      bus.flush_i = 1'b1;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL fl_ready: got %b want 0", bus.id_ready_o); end
      step();
      n_vec++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL fl_valid: got %b want 0", bus.ex_valid_o); end
      n_vec++; if (bus.ex_rd_o !== 5'd14) begin n_err++; $display("FAIL fl_data_hold: got %0d want 14", bus.ex_rd_o); end
      bus.flush_i = 1'b0; bus.ex_ready_i = 1'b1;
      bus.rs1_i = 5'd14; bus.use_rs1_i = 1'b1;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL fl_sb_kept: got %b want 0", bus.id_ready_o); end
      bus.long_done_i = 1'b1; bus.long_done_rd_i = 5'd14;
      step();
      bus.long_done_i = 1'b0;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL fl_release: got %b want 1", bus.id_ready_o); end
      step();
      n_vec++; if (bus.ex_rd_o !== 5'd5 || bus.ex_valid_o !== 1'b1) begin n_err++; $display("FAIL fl_issue: got rd %0d v %b want rd 5 v 1", bus.ex_rd_o, bus.ex_valid_o); end
   endtask

   task automatic test_reset_mid_stall;
      idle();
      bus.id_valid_i = 1'b1;
      bus.is_long_i  = 1'b1; bus.rf_wen_i = 1'b1; bus.rd_i = 5'd20;
      settle();
      step();
      bus.is_long_i = 1'b0; bus.rd_i = 5'd21;
      bus.rs1_i = 5'd20; bus.use_rs1_i = 1'b1;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", bus.id_ready_o); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      settle();
      n_vec++; if (bus.id_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.id_ready_o); end
      n_vec++; if (bus.ex_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.ex_valid_o); end
      step();
      n_vec++; if (bus.ex_rd_o !== 5'd21) begin n_err++; $display("FAIL rst_issue: got %0d want 21", bus.ex_rd_o); end
   endtask

   task automatic test_perf;
      logic [31:0] exp_stall;
`ifdef ISSUE_PERF_EN
      exp_stall = 32'd4;
`else
      exp_stall = 32'd0;
`endif
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.id_valid_i = 1'b1;
      bus.rs2_i      = 5'd7; bus.use_rs2_i = 1'b1;
      bus.fwd_wen_i  = 3'b001;
      bus.fwd_rdy_i  = 3'b000;
      bus.fwd_rd_i   = {5'd0, 5'd0, 5'd7};
      settle();
      repeat (4) step();
      bus.flush_i = 1'b1;
      step();
      bus.flush_i    = 1'b0;
      bus.id_valid_i = 1'b0;
      step();
      n_vec++; if (bus.stall_cycles_o !== exp_stall) begin n_err++; $display("FAIL perf_stall: got %0d want %0d", bus.stall_cycles_o, exp_stall); end
   endtask

   initial begin
      idle();
      test_reset();
      test_bypass_priority();
      test_load_use();
      test_x0();
      test_scoreboard();
      test_backpressure_flush();
      test_reset_mid_stall();
      test_perf();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
